down_cnt_reg: RTL and testbench
===============================

# down_cnt_reg

Loadable down-counter register that sits directly upstream of the DEC stage in the datapath library. It holds the loop/iteration count, drives DEC's A input from its register, and captures DEC's D output back on each step, so register plus DEC form a cycle-accurate countdown. A small FSM sequences load, countdown, stall, abort and a one-cycle completion pulse for the HLS controller.

## Interface

- WIDTH, 64, data width of the count, Count, Q and DecIn.

- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous reset, active-low (Rst=0 resets).
- Start  input  1  load request; sampled in IDLE or DONE only.
- Count  input  WIDTH  initial count, captured on accepted Start.
- Stall  input  1  hold current count for this cycle while in RUN.
- Abort  input  1  cancel countdown while in RUN.
- DecIn  input  WIDTH  DEC stage D output, equal to Q-1 mod 2^WIDTH.
- Q  output  WIDTH  registered current count; wired to DEC stage A.
- Zero  output  1  combinational, Q == 0.
- Busy  output  1  registered, 1 while in RUN.
- Done  output  1  registered, one-cycle completion pulse.

## Operation

- No internal subtractor: the next count in RUN is always DecIn. DEC is combinational, so DecIn is valid in the same cycle as Q.
- States are IDLE, RUN and DONE. Busy = (state==RUN) and Done = (state==DONE), both decoded from registered state.
- IDLE:
  - Start=1 and Count!=0: Q<=Count, go to RUN.
  - Start=1 and Count==0: Q<=0, go to DONE.
  - Otherwise hold.
- RUN: Start is ignored. Priority order is Abort, then Stall, then step.
  - Abort=1: Q<=0, go to IDLE, and Done is not asserted.
  - Stall=1: hold Q and state.
  - Step with Q==1: Q<=DecIn (0), go to DONE.
  - Step with Q>1: Q<=DecIn, stay in RUN.
- DONE: lasts exactly one cycle with Q=0.
  - Start=1 is accepted exactly as in IDLE, allowing back-to-back countdowns.
  - Otherwise go to IDLE.
  - Abort and Stall have no effect.
- Abort and Stall outside RUN have no effect.
- No wrap-around: Q never steps past 0. RUN is never entered with Q==0, and the step from Q==1 exits RUN.
- Count = 2^WIDTH-1 is legal and counts down fully.
- Reset (asynchronous, any state, including mid-countdown): state=IDLE, Q=0, Busy=0, Done=0, Zero=1. Operation restarts only on a new Start after Rst deasserts.

## Timing

- Start accepted at edge k with Count=N≥1:
  - Q=N and Busy=1 after edge k.
  - With no stalls, Q=N-j after edge k+j.
  - Q=0, Busy=0 and Done=1 after edge k+N.
  - Back in IDLE after edge k+N+1 unless Start is restarted.
- Each stalled cycle adds exactly one cycle of latency.
- Count=0: Done=1 after edge k, Busy never asserted.
- Abort sampled at edge m in RUN: Q=0, Busy=0, Done=0 after edge m.
- Zero follows Q combinationally, with no extra register stage.

## Test plan

- Reset, then Start with Count=3, no stall: Q reads 3,2,1,0 on successive cycles, Busy=1 for 3 cycles, Done=1 for exactly one cycle when Q=0, then IDLE.
- Count=5 with Stall=1 on the 2nd and 3rd RUN cycles: Q sequence is 5,4,4,4,3,2,1,0 and Done is asserted 7 cycles after the Start edge.
- Count=0: Done=1 on the next cycle, Busy stays 0. Count=2^WIDTH-1 with WIDTH=8 (255) reaches Done after 255 steps with no wrap to 255.
- Abort while Q=7 with Stall=1 in the same cycle: Q=0, Busy=0, Done never pulses. Start during RUN is ignored and Q continues decrementing.
- Start with Count=2 held high in the DONE cycle of a prior run: Q=2 and RUN are entered immediately with no IDLE gap.
- Rst=0 asynchronously mid-count (Q=40) between clock edges: Q=0, Busy=0, Done=0 immediately. After release, Q stays 0 until the next Start.

Source files
------------

// File: rtl/down_cnt_reg.sv
// Loadable down-counter register feeding the DEC stage.
// Q drives DEC's A input and DEC's D output (DecIn) is captured back on each
// step, so the register and DEC together form the countdown. A three-state
// FSM sequences load, countdown, stall, abort and a one-cycle Done pulse.
module down_cnt_reg #(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] Count,
  input  logic             Stall,
  input  logic             Abort,
  input  logic [WIDTH-1:0] DecIn,
  output logic [WIDTH-1:0] Q,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Q==1 marks the final step: DecIn will be 0 and RUN must be left.
  logic last_step;
  assign last_step = (cnt_q == {{(WIDTH-1){1'b0}}, 1'b1});

  // Next-state/next-count selection; outputs are decoded from the next state
  // so Busy and Done come straight out of flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        // Start is honoured in DONE too, giving back-to-back countdowns.
        if (Start) begin
          cnt_d   = Count;
          state_d = (Count != '0) ? RUN : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (Abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (!Stall) begin
          cnt_d   = DecIn;
          state_d = last_step ? DONE : RUN;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, count and registered status flags; reset may hit mid-countdown.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q    = cnt_q;
  assign Zero = (cnt_q == '0);
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_down_cnt_reg.sv
// Bench for down_cnt_reg at WIDTH=8: directed scenarios plus random traffic,
// scored against a countdown model through an expectation queue.
module tb_down_cnt_reg;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         Start = 1'b0;
  logic [W-1:0] Count = '0;
  logic         Stall = 1'b0;
  logic         Abort = 1'b0;
  logic [W-1:0] DecIn;
  logic [W-1:0] Q;
  logic         Zero, Busy, Done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int q;
    bit busy;
    bit done;
  } exp_t;

  exp_t exp_fifo[$];

  // Reference: remaining count plus "counting" / "just finished" flags.
  int m_rem  = 0;
  bit m_cnt  = 0;
  bit m_fin  = 0;

  down_cnt_reg #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Count(Count), .Stall(Stall),
    .Abort(Abort), .DecIn(DecIn), .Q(Q), .Zero(Zero), .Busy(Busy), .Done(Done)
  );

  // The DEC stage: D = A - 1 mod 2^W.
  assign DecIn = Q - 8'd1;

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs and record what the model says should be
  // visible after the coming rising edge.
  task automatic step(input bit st, input int cnt, input bit sl, input bit ab);
    @(negedge Clk);
    Start = st;
    Count = cnt[W-1:0];
    Stall = sl;
    Abort = ab;
    if (!Rst) begin
      m_rem = 0; m_cnt = 0; m_fin = 0;
    end else if (m_cnt) begin
      if (ab) begin
        m_rem = 0; m_cnt = 0; m_fin = 0;
      end else if (!sl) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin m_cnt = 0; m_fin = 1; end
      end
    end else if (st) begin
      m_rem = cnt % (1 << W);
      m_cnt = (m_rem != 0);
      m_fin = (m_rem == 0);
    end else begin
      m_fin = 0;
    end
    exp_fifo.push_back('{q: m_rem, busy: m_cnt, done: m_fin});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  // Check the immediate effect of an asynchronous reset.
  task automatic chk_reset(input string tag);
    #1;
    chk({tag, "_q"},    int'(Q), 0);
    chk({tag, "_busy"}, int'(Busy), 0);
    chk({tag, "_done"}, int'(Done), 0);
    chk({tag, "_zero"}, int'(Zero), 1);
    m_rem = 0; m_cnt = 0; m_fin = 0;
  endtask

  // Monitor: after every edge, pop the expectation and compare.
  always @(posedge Clk) begin
    #1;
    if (exp_fifo.size() > 0) begin
      exp_t e;
      e = exp_fifo.pop_front();
      chk("q",    int'(Q),    e.q);
      chk("busy", int'(Busy), int'(e.busy));
      chk("done", int'(Done), int'(e.done));
      chk("zero", int'(Zero), int'(e.q == 0));
    end
  end

  initial begin
    // Power-on reset between edges.
    #2 Rst = 1'b0;
    chk_reset("por");
    idle(2);
    @(negedge Clk) Rst = 1'b1;
    idle(2);

    // Plain countdown from 3.
    step(1, 3, 0, 0);
    idle(5);

    // Count 5, stalls on the 2nd and 3rd RUN cycles.
    step(1, 5, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    idle(6);

    // Count 0 finishes immediately; Abort/Stall outside RUN are ignored.
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    idle(1);

    // Full-range count, no wrap.
    step(1, 255, 0, 0);
    idle(258);

    // Start during RUN is ignored; Abort beats Stall at Q=7.
    step(1, 10, 0, 0);
    step(1, 99, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 50, 1, 1);
    idle(3);

    // Back-to-back: Start held in the DONE cycle.
    step(1, 1, 0, 0);
    step(1, 2, 0, 0);
    step(1, 2, 0, 0);
    idle(4);

    // Async reset mid-countdown at Q=40.
    step(1, 50, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    @(posedge Clk);
    #3;
    Rst = 1'b0;
    chk_reset("async");
    step(0, 0, 0, 0);
    step(1, 7, 0, 0);
    @(negedge Clk) Rst = 1'b1;
    Start = 1'b0;
    idle(3);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit st, sl, ab;
      int c;
      st = ($urandom_range(0, 3) == 0);
      sl = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 19) == 0);
      c  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                       : int'($urandom_range(0, 6));
      step(st, c, sl, ab);
    end
    idle(2);

    @(posedge Clk);
    #3;
    chk("fifo_drained", exp_fifo.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
